// File: rtl/pulse_stretch.sv
// Multi-channel pulse stretcher: each trigger holds its channel's q high for max(len,1)
// cycles, with optional retrigger and a one-cycle done pulse when a stretch ends.
module pulse_stretch #(
    parameter int unsigned W         = 1,
    parameter int unsigned CNT_W     = 8,
    parameter bit          RETRIGGER = 1'b1
) (
    input  logic             c,
    input  logic             r,
    input  logic [CNT_W-1:0] len,
    input  logic [W-1:0]     d,
    output logic [W-1:0]     q,
    output logic [W-1:0]     done,
    output logic             busy
);

    logic [CNT_W-1:0] cnt_q [W];
    logic [CNT_W-1:0] cnt_d [W];
    logic [W-1:0]     q_q, q_d;
    logic [W-1:0]     done_q, done_d;
    logic [W-1:0]     active, last, accept;
    logic [CNT_W-1:0] load_val;

    assign load_val = (len == '0) ? CNT_W'(1) : len;

    always_comb begin
        active = '0;
        last   = '0;
        accept = '0;
        q_d    = '0;
        done_d = '0;
        for (int i = 0; i < W; i++) begin
            cnt_d[i]  = cnt_q[i];
            active[i] = (cnt_q[i] != '0);
            last[i]   = (cnt_q[i] == CNT_W'(1));
            // Without retrigger, the final cycle still accepts so stretches chain back-to-back.
            accept[i] = d[i] && (!active[i] || RETRIGGER || last[i]);
            if (accept[i]) begin
                cnt_d[i] = load_val;
            end else if (active[i]) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
            q_d[i]    = (cnt_d[i] != '0);
            done_d[i] = active[i] && !q_d[i];
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= '0;
            end
            q_q    <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < W; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            q_q    <= q_d;
            done_q <= done_d;
        end
    end

    assign q    = q_q;
    assign done = done_q;
    assign busy = |q_q;

endmodule

// File: tb/tb_pulse_stretch.sv
// Scoreboard bench for pulse_stretch: a time-based model of each channel's stretch end
// predicts q/done/busy for a retriggering and a non-retriggering instance in parallel.
module tb_pulse_stretch;

    localparam int unsigned W     = 4;
    localparam int unsigned CNT_W = 8;

    logic             c = 1'b0;
    logic             r;
    logic [CNT_W-1:0] len;
    logic [W-1:0]     d;
    logic [W-1:0]     q1, done1, q0, done0;
    logic             busy1, busy0;

    pulse_stretch #(.W(W), .CNT_W(CNT_W), .RETRIGGER(1'b1)) u_rt (
        .c(c), .r(r), .len(len), .d(d), .q(q1), .done(done1), .busy(busy1)
    );

    pulse_stretch #(.W(W), .CNT_W(CNT_W), .RETRIGGER(1'b0)) u_nort (
        .c(c), .r(r), .len(len), .d(d), .q(q0), .done(done0), .busy(busy0)
    );

    always #5 c = ~c;

    typedef struct packed {
        logic [W-1:0] q1;
        logic [W-1:0] d1;
        logic [W-1:0] q0;
        logic [W-1:0] d0;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    // Last cycle in which each channel's q is high; -1 means idle since reset.
    int   end_c [2][W];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    endtask

    task automatic step(input logic rv, input logic [W-1:0] dv, input logic [CNT_W-1:0] lv);
        exp_t e;
        int   l;
        logic acc;
        r   = rv;
        d   = dv;
        len = lv;
        l   = (lv == 0) ? 1 : int'(lv);
        e   = '0;
        for (int v = 0; v < 2; v++) begin
            for (int i = 0; i < W; i++) begin
                logic qn, dn;
                if (rv) begin
                    end_c[v][i] = -1;
                    qn = 1'b0;
                    dn = 1'b0;
                end else begin
                    acc = dv[i] && (end_c[v][i] < cyc || v == 1 || end_c[v][i] == cyc);
                    dn  = (end_c[v][i] == cyc) && !acc;
                    if (acc) end_c[v][i] = cyc + l;
                    qn  = (end_c[v][i] >= cyc + 1);
                end
                if (v == 1) begin
                    e.q1[i] = qn;
                    e.d1[i] = dn;
                end else begin
                    e.q0[i] = qn;
                    e.d0[i] = dn;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge c);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check("q_rt", 32'(q1), 32'(e.q1));
        check("done_rt", 32'(done1), 32'(e.d1));
        check("busy_rt", 32'(busy1), 32'(|e.q1));
        check("q_nort", 32'(q0), 32'(e.q0));
        check("done_nort", 32'(done0), 32'(e.d0));
        check("busy_nort", 32'(busy0), 32'(|e.q0));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, '0, 8'd0);
    endtask

    initial begin
        r   = 1'b1;
        d   = '0;
        len = '0;
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < W; i++) end_c[v][i] = -1;

        // Reset with a trigger present must be ignored.
        step(1'b1, 4'b1111, 8'd4);
        step(1'b1, '0, 8'd0);
        // Basic 4-cycle stretch, trigger in first cycle out of reset.
        step(1'b0, 4'b0001, 8'd4);
        idle(6);
        // Triggers at n, n+3, n+5 with len=5: retrigger vs back-to-back behaviour.
        step(1'b0, 4'b0001, 8'd5);
        idle(2);
        step(1'b0, 4'b0001, 8'd5);
        idle(1);
        step(1'b0, 4'b0001, 8'd5);
        idle(12);
        // len=0 behaves as 1.
        step(1'b0, 4'b0001, 8'd0);
        idle(3);
        // Trigger in the done cycle is accepted as fresh.
        step(1'b0, 4'b0010, 8'd2);
        idle(2);
        step(1'b0, 4'b0010, 8'd2);
        idle(4);
        // Maximum length.
        step(1'b0, 4'b1000, 8'd255);
        idle(258);
        // Reset mid-stretch with a concurrent trigger, then a fresh stretch.
        step(1'b0, 4'b0001, 8'd10);
        idle(3);
        step(1'b1, 4'b0001, 8'd10);
        idle(2);
        step(1'b0, 4'b0001, 8'd10);
        idle(12);
        // Independent channels sharing len.
        step(1'b0, 4'b0101, 8'd3);
        step(1'b0, 4'b0010, 8'd3);
        idle(5);
        // Random traffic with short lengths so acceptance rules are exercised often.
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 60) == 0), 4'($urandom), 8'($urandom_range(0, 6)));
        end
        idle(8);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pulse_stretch.md
PULSE_STRETCH -- requirements
Module: pulse_stretch

Interface
REQ-001: Parameter W, default 1, number of independent channels.
REQ-002: Parameter CNT_W, default 8, width of the length operand and of each per-channel counter.
REQ-003: Parameter RETRIGGER, default 1: 1 means a trigger during an active pulse reloads the counter; 0 means such triggers are ignored, except as REQ-013 allows.
REQ-004: c  input  1  sole clock; all state updates on the rising edge.
REQ-005: r  input  1  reset; synchronous, active-high.
REQ-006: len  input  CNT_W  stretch length in cycles; sampled only in the cycle a trigger is accepted.
REQ-007: d  input  W  per-channel trigger; each cycle d[i]=1 is one trigger event, with no edge detection inside the block.
REQ-008: q  output  W  per-channel stretched level, registered.
REQ-009: done  output  W  per-channel one-cycle pulse marking the end of a stretch, registered.
REQ-010: busy  output  1  OR of all q bits.

Function
REQ-011: Each channel i SHALL hold a CNT_W-bit counter cnt[i] and two states: IDLE (cnt[i]=0) and ACTIVE (cnt[i]!=0).
REQ-012: A trigger SHALL be accepted in IDLE regardless of RETRIGGER.
- On acceptance: cnt[i] <= max(len,1).
- len=0 SHALL be treated as 1.
REQ-013: Acceptance while ACTIVE:
- RETRIGGER=1: accepted in any ACTIVE cycle, cnt[i] <= max(len,1).
- RETRIGGER=0: accepted only when cnt[i]=1 (final cycle), giving back-to-back stretches; otherwise ignored.
REQ-014: ACTIVE with no accepted trigger: cnt[i] <= cnt[i]-1; no wrap below 0.
REQ-015: q[i] SHALL be registered so that q[i]=1 exactly in cycles where cnt[i]!=0.
- A trigger accepted at edge n from IDLE gives q[i]=1 for cycles n+1 .. n+L, where L=max(len,1).
- Latency trigger->q is 1 cycle.
REQ-016: done[i] SHALL be 1 for exactly the one cycle after the final cycle of q[i]=1 (first cycle q[i] is low again). It SHALL NOT assert when a retrigger or back-to-back acceptance keeps q[i] continuously high.
REQ-017: A trigger arriving in the same cycle done[i]=1 SHALL be accepted as from IDLE; done[i] still pulses that cycle.
REQ-018: Channels SHALL be fully independent; simultaneous triggers on several channels SHALL all sample the same len.
REQ-019: Maximum stretch SHALL be 2^CNT_W-1 cycles; len is unsigned, no saturation logic beyond REQ-012.
REQ-020: busy SHALL be a combinational OR of the registered q bits (no added latency).

Reset
REQ-021: While r=1 at a rising edge, all cnt, q and done SHALL become 0 at that edge, including mid-stretch; busy then reads 0.
REQ-022: Triggers present in a cycle with r=1 SHALL be ignored.
REQ-023: Reset abort of an active stretch SHALL NOT produce a done pulse.
REQ-024: First trigger accepted is in the first cycle with r=0.

Verification
REQ-025: W=1, len=4, one-cycle d pulse at edge n -> q=1 for edges n+1..n+4, done=1 at n+5, busy mirrors q.
REQ-026: RETRIGGER=1, len=5, d at n and n+3 -> q continuously 1 for n+1..n+8, single done at n+9.
REQ-027: RETRIGGER=0, len=5, d at n, n+3, n+5 -> the n+3 trigger is ignored and n+5 is accepted (cnt=1), so q=1 for n+1..n+10 and done at n+11 only.
REQ-028: len=0 trigger -> q=1 for exactly one cycle, done the next; len=255, CNT_W=8 -> q=1 for 255 cycles.
REQ-029: len=10 stretch, r=1 asserted at the 4th active cycle together with a d pulse -> q=0 and done=0 from the next edge; no done pulse; a d after r drops restarts a fresh 10-cycle stretch.
REQ-030: W=4, len=3, d=4'b0101 at n, d=4'b0010 at n+1 -> q[0],q[2] high n+1..n+3, q[1] high n+2..n+4, q[3] never; done per channel at the correct cycle.
